// File: rtl/spart_rx_fifo.sv
// +----------------------------------------------------------------------------+
// | spart_rx_fifo : oversampling SPART receiver with optional parity and FIFO   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none

module spart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Enable,
  input  logic                 RxD,
  input  logic                 IORW,
  input  logic [1:0]           IOADDR,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 RDA,
  output logic [7:0]           STATUS
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);
  localparam logic          ODD_BIT   = (PARITY_ODD != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_BREAK  = 3'd5;

  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic [2:0]           state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, wptr_d;
  logic [AW-1:0]        rptr_q, rptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 oe_q, oe_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;

  logic        push_req, pe_set, fe_set, oe_set;
  logic        empty, full, pop, clr, wr;
  logic [31:0] cnt_ext;
  logic [3:0]  sts_cnt;

  // Receive FSM; every sample is taken from the synchronised line on Enable ticks
  always_comb begin
    sync1_d  = RxD;
    rxs_d    = sync1_q;
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    push_req = 1'b0;
    pe_set   = 1'b0;
    fe_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Enable && !rxs_q) begin
          state_d = S_START;
          tick_d  = '0;
        end
      end
      S_START: begin
        if (Enable) begin
          if (tick_q == TICK_MID) begin
            if (rxs_q) begin
              state_d = S_IDLE;
            end else begin
              state_d = S_DATA;
              tick_d  = '0;
              bit_d   = '0;
              perr_d  = 1'b0;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (Enable) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_d   = '0;
              state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (Enable) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            perr_d  = rxs_q ^ (^shift_q) ^ ODD_BIT;
            state_d = S_STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (Enable) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxs_q) begin
              push_req = !perr_q;
              pe_set   = perr_q;
              state_d  = S_IDLE;
            end else begin
              fe_set  = 1'b1;
              state_d = S_BREAK;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      S_BREAK: begin
        if (Enable && rxs_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A full FIFO still accepts a push when the same cycle pops the head
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CNT_FULL);
    pop     = ({IORW, IOADDR} == 3'b100) && !empty;
    clr     = ({IORW, IOADDR} == 3'b101);
    wr      = push_req && (!full || pop);
    oe_set  = push_req && full && !pop;
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (wr) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({wr, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    oe_d = (oe_q & ~clr) | oe_set;
    fe_d = (fe_q & ~clr) | fe_set;
    pe_d = (pe_q & ~clr) | pe_set;
  end

  always_comb begin
    cnt_ext = 32'(count_q);
    sts_cnt = (cnt_ext > 32'd15) ? 4'hF : cnt_ext[3:0];
    RDA     = !empty;
    DATA    = empty ? '0 : mem_q[rptr_q];
    STATUS  = {oe_q, fe_q, pe_q, full, sts_cnt};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
      state_q <= S_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      mem_q   <= '{default: '0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      oe_q    <= 1'b0;
      fe_q    <= 1'b0;
      pe_q    <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      rxs_q   <= rxs_d;
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      mem_q   <= mem_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      oe_q    <= oe_d;
      fe_q    <= fe_d;
      pe_q    <= pe_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/spart_rx_fifo.md
Name: spart_rx_fifo

Overview:
Parametrised SPART receive channel, next generation of the serial receiver. It oversamples RxD on the baud Enable tick and validates the start bit at mid-bit. It supports configurable data width, optional parity and a receive FIFO, and reports framing, parity and overrun errors. It sits between the RxD pin and the SPART bus interface, where the driver pops data and reads and clears status over IORW/IOADDR.

Parameters:
DATA_BITS, 8, data bits per frame, 5..9, LSB first.
OVERSAMPLE, 16, Enable ticks per bit, even, >=8.
FIFO_DEPTH, 4, receive FIFO entries, power of 2, >=2.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
Enable  in  1  one-cycle baud tick at OVERSAMPLE x bit rate.
RxD  in  1  serial input, asynchronous, idle high.
IORW  in  1  1 = driver read.
IOADDR  in  2  00 = data, 01 = status.
DATA  out  DATA_BITS  FIFO head word, combinational from FIFO storage; 0 when empty.
RDA  out  1  FIFO not empty.
STATUS  out  8  {OE, FE, PE, FULL, count[3:0]}; count saturates at 15 in this field.

Behaviour:
- Reset: all of the following are cleared.
  - FIFO empty; RDA=0, DATA=0, STATUS=0.
  - FSM in IDLE; tick and bit counters 0.
  - Both RxD synchroniser flops set to 1.
- RxD passes through a 2-flop synchroniser (rxs). All sampling uses rxs and happens only on cycles with Enable=1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on an Enable tick with rxs=0, go to START with tick=0.
  - START: tick increments per Enable tick. At tick==OVERSAMPLE/2-1, sample rxs:
    - rxs=1: false start, return to IDLE.
    - rxs=0: go to DATA with tick=0, bit=0.
  - DATA: sample when tick==OVERSAMPLE-1, then reset tick. Shift the sample into the shift register at the MSB and shift right. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
  - PARITY: sample at tick==OVERSAMPLE-1. Compare against the XOR of the data bits, XORed with PARITY_ODD. A mismatch sets the internal perr bit.
  - STOP: sample at tick==OVERSAMPLE-1.
    - rxs=1 and perr=0: push the word and go to IDLE.
    - rxs=1 and perr=1: set PE, discard the word, go to IDLE.
    - rxs=0: set FE, discard the word, go to BREAK.
  - BREAK: wait for an Enable tick with rxs=1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Latency: RDA rises on the clock edge after the stop-sample Enable cycle, provided the FIFO was not full.
- FIFO:
  - Pop on any cycle with {IORW,IOADDR}==3'b100 and RDA=1. A pop with RDA=0 is ignored, with no state change.
  - Push when full: word dropped, OE set, contents unchanged.
  - Push and pop in the same cycle:
    - count unchanged, including when full (no OE).
    - When empty, only the push takes effect.
  - Pointers wrap modulo FIFO_DEPTH. FULL = (count==FIFO_DEPTH).
- Errors:
  - OE, FE and PE are sticky.
  - A cycle with {IORW,IOADDR}==3'b101 clears all three.
  - If a new error occurs in the same cycle as the clear, the new error flag ends set.
- rst asserted mid-frame: immediate return to reset state; the partial frame is lost.
- Counters: tick is clog2(OVERSAMPLE) bits, bit counter is 4 bits, count is clog2(FIFO_DEPTH)+1 bits.

Test Plan:
- Defaults (8N1, x16): send 0xA5 at 16 ticks/bit -> after the stop sample, RDA=1, DATA=0xA5, STATUS=0x01. Read data -> RDA=0, STATUS=0x00.
- Send 0x01,0x02,0x03,0x04,0x05 with no reads -> FULL=1, OE=1, STATUS=0x94. Pops return 0x01..0x04, then RDA=0. Status read -> OE=0.
- Glitch: RxD low for 4 ticks, then high -> FSM returns to IDLE, RDA stays 0. A subsequent 0x5A is received correctly.
- Framing: 0x3C with stop bit 0, line held low for 20 bit-times, then high -> nothing pushed, FE=1, no extra frames. Next 0x11 is received, RDA=1.
- PARITY_EN=1, PARITY_ODD=0: 0x07 with parity 0 -> PE=1, not pushed. 0x07 with parity 1 -> DATA=0x07. Status read in the same cycle as the PE-setting stop sample -> PE=1.
- Simultaneous push and pop with the FIFO full (4 entries) -> count stays 4, OE=0, the new word appears after 3 pops. Assert rst mid-DATA -> RDA=0, STATUS=0, next frame received cleanly.
